commit_unit: RTL
================

# commit_unit

In-order retirement stage directly downstream of the reorder buffer. Each cycle it accepts at most one ready head entry from the ROB and drives the handshake that pops it. By entry type it writes the architectural register file, acknowledges a store, or redirects fetch and broadcasts a pipeline flush on a mispredicted control-flow instruction. It also keeps retire and mispredict counters for debug.

## Interface
- FLUSH_CYCLES, 1: cycles `rst_c_o` stays high per mispredict (1..15).
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; low freezes all state
- commit_en_i  in  1  ROB head entry valid and ready
- commit_id_i  in  5  ROB index of head entry
- commit_regaddr_i  in  5  destination register
- commit_data_i  in  32  result / link value
- commit_pc_i  in  32  redirect target
- commit_branch_tag_i  in  2  00 ALU, 01 branch, 10 jump, 11 store
- commit_cond_i  in  1  1 = redirect required (mispredict)
- commit_rdy_o  out  1  pop head this cycle (combinational)
- we_o  out  1  register-file write strobe
- waddr_o  out  5  register-file write address
- wdata_o  out  32  register-file write data
- wid_o  out  5  ROB id being retired (regfile clears rename tag if equal)
- st_commit_o  out  1  store retired pulse to load/store buffer
- pc_en_o  out  1  fetch redirect strobe
- pc_o  out  32  fetch redirect target
- rst_c_o  out  1  pipeline flush
- retired_cnt_o  out  32  instructions retired since reset
- mispred_cnt_o  out  16  mispredicts since reset

## Operation
- States: IDLE, FLUSH. Reset: IDLE, flush counter 0, every output 0 (`commit_rdy_o` 0 while `rst`).
- `commit_rdy_o = commit_en_i && rdy && !rst && state==IDLE`. The ROB advances its head in the same cycle.
- On accept (commit_rdy_o=1), registered for next cycle:
  - `wid_o <= commit_id_i`; `retired_cnt_o += 1`, wraps at 2^32.
  - Tag 00: `we_o=1`, `waddr_o/wdata_o` from inputs.
  - Tag 01: no write. If `commit_cond_i`, mispredict.
  - Tag 10: write as tag 00 (link value). If `commit_cond_i`, mispredict.
  - Tag 11: `st_commit_o=1`, no write.
  - `we_o` is forced 0 when `commit_regaddr_i==0`. `waddr_o/wdata_o` still update.
- Mispredict actions:
  - `pc_en_o=1`, `pc_o=commit_pc_i`, `rst_c_o=1`.
  - `mispred_cnt_o += 1`; it saturates at 16'hFFFF.
  - Enter FLUSH with counter = FLUSH_CYCLES.
- FLUSH state:
  - `commit_rdy_o=0`. Wrong-path `commit_en_i` is ignored.
  - Counter decrements on each rdy-high cycle. At 1→0: `rst_c_o<=0`, return to IDLE.
  - Register write of the mispredicting jump still occurs; younger entries never retire.
- Pulses: `we_o`, `st_commit_o`, `pc_en_o` are high for exactly one cycle after an accept. They are 0 in any cycle without an accept, including rdy-low cycles.
- rdy low: state, counters, `rst_c_o`, `pc_o`, `waddr_o`, `wdata_o`, `wid_o` hold.
- `rst` mid-FLUSH: immediate return to IDLE, `rst_c_o=0` next edge, counters cleared.

## Timing
- Accept at edge-cycle t gives outputs at t+1. Latency 1, throughput 1 retire/cycle.
- Mispredict accepted at t:
  - `rst_c_o` high t+1 … t+FLUSH_CYCLES (rdy-high cycles).
  - `pc_en_o` high at t+1 only.
  - First new accept possible at t+FLUSH_CYCLES+1.
- `commit_rdy_o` has no register stage. Its path is `commit_en_i`/`rdy`/state → output only.

## Test plan
- Reset: hold `rst` 2 cycles with `commit_en_i=1`. Required: `commit_rdy_o=0`; after release, all outputs 0 and counters 0.
- Stream of 4 tag-00 entries (ids 0-3, rd 5, data 0x11..0x44), `commit_en_i` high for 4 cycles. Required: `commit_rdy_o` high 4 cycles, `we_o` high t+1..t+4 with matching data, `retired_cnt_o=4`.
- Tag 00 with rd=0, data 0xDEAD. Required: `commit_rdy_o=1`, `we_o=0`, `retired_cnt_o` increments.
- Tag 01, cond=1, pc 0x1000, FLUSH_CYCLES=2, `commit_en_i` held high. Required:
  - `pc_en_o` one cycle with `pc_o=0x1000`.
  - `rst_c_o` high 2 cycles, `commit_rdy_o` low 2 cycles, then resumes.
  - `mispred_cnt_o=1`.
- Tag 10, cond=1, rd 1, data 0x8, pc 0x200. Required: `we_o=1` `waddr_o=1` `wdata_o=0x8` and redirect to 0x200 in the same cycle.
- Tag 11 accept, then `rdy` low 3 cycles mid-FLUSH. Required:
  - `st_commit_o` one-cycle pulse, no `we_o`.
  - Flush counter and `rst_c_o` frozen while rdy is low; flush completes after the remaining rdy-high cycles.

Source files
------------

// File: rtl/commit_unit_if.sv
// commit_unit_if: reorder-buffer head handshake between the ROB (master)
// and the commit stage (slave).
//   commit_en_i          head entry valid and ready
//   commit_id_i          ROB index of the head entry
//   commit_regaddr_i     destination register
//   commit_data_i        result / link value
//   commit_pc_i          redirect target
//   commit_branch_tag_i  00 ALU, 01 branch, 10 jump, 11 store
//   commit_cond_i        1 = mispredicted, redirect required
//   commit_rdy_o         head popped this cycle (from commit stage)
interface commit_unit_if;
   logic        commit_en_i;
   logic [4:0]  commit_id_i;
   logic [4:0]  commit_regaddr_i;
   logic [31:0] commit_data_i;
   logic [31:0] commit_pc_i;
   logic [1:0]  commit_branch_tag_i;
   logic        commit_cond_i;
   logic        commit_rdy_o;

   modport master (
      output commit_en_i, commit_id_i, commit_regaddr_i, commit_data_i,
             commit_pc_i, commit_branch_tag_i, commit_cond_i,
      input  commit_rdy_o
   );

   modport slave (
      input  commit_en_i, commit_id_i, commit_regaddr_i, commit_data_i,
             commit_pc_i, commit_branch_tag_i, commit_cond_i,
      output commit_rdy_o
   );
endinterface

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage behind the reorder buffer.
// Accepts at most one head entry per cycle, writes the register file,
// retires stores, and on a mispredicted branch/jump redirects fetch and
// holds the pipeline flush for FLUSH_CYCLES rdy-high cycles.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   rdy            global ready; low freezes all state
//   rob            ROB head handshake (slave side)
//   we_o/waddr_o/wdata_o   register-file write
//   wid_o          ROB id of the last retired entry
//   st_commit_o    store retired pulse
//   pc_en_o/pc_o   fetch redirect
//   rst_c_o        pipeline flush
//   retired_cnt_o  retired instructions (wraps)
//   mispred_cnt_o  mispredicts (saturates)
//
// state  | meaning
// IDLE   | accepting head entries
// FLUSH  | mispredict flush in progress, head is not popped
module commit_unit #(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   commit_unit_if.slave rob,
   output logic        we_o,
   output logic [4:0]  waddr_o,
   output logic [31:0] wdata_o,
   output logic [4:0]  wid_o,
   output logic        st_commit_o,
   output logic        pc_en_o,
   output logic [31:0] pc_o,
   output logic        rst_c_o,
   output logic [31:0] retired_cnt_o,
   output logic [15:0] mispred_cnt_o
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   localparam logic [1:0] TAG_ALU   = 2'b00;
   localparam logic [1:0] TAG_BR    = 2'b01;
   localparam logic [1:0] TAG_JMP   = 2'b10;
   localparam logic [1:0] TAG_STORE = 2'b11;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

   logic [0:0]  state_q, state_d;
   logic [3:0]  flush_cnt_q, flush_cnt_d;
   logic        we_q, we_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  wid_q, wid_d;
   logic        st_commit_q, st_commit_d;
   logic        pc_en_q, pc_en_d;
   logic [31:0] pc_q, pc_d;
   logic        rst_c_q, rst_c_d;
   logic [31:0] retired_cnt_q, retired_cnt_d;
   logic [15:0] mispred_cnt_q, mispred_cnt_d;

   logic accept;
   logic mispred;
   logic writes_reg;

   // Combinational pop: the ROB advances its head in the same cycle.
   assign accept = rob.commit_en_i && rdy && !rst && (state_q == S_IDLE);
   assign rob.commit_rdy_o = accept;

   assign writes_reg = (rob.commit_branch_tag_i == TAG_ALU) ||
                       (rob.commit_branch_tag_i == TAG_JMP);
   assign mispred    = accept && rob.commit_cond_i &&
                       ((rob.commit_branch_tag_i == TAG_BR) ||
                        (rob.commit_branch_tag_i == TAG_JMP));

   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      waddr_d       = waddr_q;
      wdata_d       = wdata_q;
      wid_d         = wid_q;
      pc_d          = pc_q;
      rst_c_d       = rst_c_q;
      retired_cnt_d = retired_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      // Strobes are single-cycle: low unless this cycle accepts.
      we_d          = 1'b0;
      st_commit_d   = 1'b0;
      pc_en_d       = 1'b0;

      if (accept) begin
         wid_d         = rob.commit_id_i;
         retired_cnt_d = retired_cnt_q + 32'd1;
         if (writes_reg) begin
            waddr_d = rob.commit_regaddr_i;
            wdata_d = rob.commit_data_i;
            // x0 is hardwired; address/data still track the entry.
            we_d    = (rob.commit_regaddr_i != 5'd0);
         end
         if (rob.commit_branch_tag_i == TAG_STORE) begin
            st_commit_d = 1'b1;
         end
         if (mispred) begin
            pc_en_d       = 1'b1;
            pc_d          = rob.commit_pc_i;
            rst_c_d       = 1'b1;
            mispred_cnt_d = (mispred_cnt_q == 16'hFFFF) ? mispred_cnt_q
                                                        : mispred_cnt_q + 16'd1;
            state_d       = S_FLUSH;
            flush_cnt_d   = FLUSH_INIT;
         end
      end else if ((state_q == S_FLUSH) && rdy) begin
         // <=1 also recovers cleanly from an out-of-range count of 0.
         if (flush_cnt_q <= 4'd1) begin
            flush_cnt_d = 4'd0;
            rst_c_d     = 1'b0;
            state_d     = S_IDLE;
         end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         flush_cnt_q   <= 4'd0;
         we_q          <= 1'b0;
         waddr_q       <= 5'd0;
         wdata_q       <= 32'd0;
         wid_q         <= 5'd0;
         st_commit_q   <= 1'b0;
         pc_en_q       <= 1'b0;
         pc_q          <= 32'd0;
         rst_c_q       <= 1'b0;
         retired_cnt_q <= 32'd0;
         mispred_cnt_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         we_q          <= we_d;
         waddr_q       <= waddr_d;
         wdata_q       <= wdata_d;
         wid_q         <= wid_d;
         st_commit_q   <= st_commit_d;
         pc_en_q       <= pc_en_d;
         pc_q          <= pc_d;
         rst_c_q       <= rst_c_d;
         retired_cnt_q <= retired_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign we_o          = we_q;
   assign waddr_o       = waddr_q;
   assign wdata_o       = wdata_q;
   assign wid_o         = wid_q;
   assign st_commit_o   = st_commit_q;
   assign pc_en_o       = pc_en_q;
   assign pc_o          = pc_q;
   assign rst_c_o       = rst_c_q;
   assign retired_cnt_o = retired_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule
